rans_enc_fetch: RTL and testbench

//  Upstream feeder for the rANS decoder top: turns the byte pointer (ByteIndex) into the
//  3-byte window EncBytes and the seed BottomWord, read from a 32-bit word-wide encoded-file RAM.

---
 rtl/rans_enc_fetch.sv | 172 +++++++++++++++++
 tb/tb_rans_enc_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rans_enc_fetch.sv
// Byte-window feeder for the rANS decoder: maps byte_index onto a two-word cache
// of the encoded-file RAM and produces the 3-byte window plus the boot-time bottom word.
module rans_enc_fetch #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              restart,
   input  logic [31:0]       byte_index,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic [23:0]       enc_bytes,
   output logic [31:0]       bottom_word,
   output logic              win_valid,
   output logic              boot_done
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      BOOT_LO   = 3'd1,
      BOOT_HI   = 3'd2,
      BOOT_CAP  = 3'd3,
      READY     = 3'd4,
      SHIFT_CAP = 3'd5,
      MISS_HI   = 3'd6,
      MISS_CAP  = 3'd7
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_TWO  = {{(ADDR_W-2){1'b0}}, 2'b10};

   state_t            state_r;
   logic [31:0]       lo_r;
   logic [31:0]       hi_r;
   logic [ADDR_W-1:0] base_r;
   logic [ADDR_W-1:0] base_req_r;

   logic [ADDR_W-1:0] addr_a_s;
   logic [1:0]        off_s;
   logic [ADDR_W-1:0] base_p1_s;
   logic [ADDR_W-1:0] base_p2_s;
   logic [ADDR_W-1:0] req_p1_s;
   logic              a_eq_base_s;
   logic              a_eq_next_s;
   logic [63:0]       cache_s;
   logic              unused_hi_s;

   assign addr_a_s    = byte_index[ADDR_W+1:2];
   assign off_s       = byte_index[1:0];
   assign unused_hi_s = ^byte_index[31:ADDR_W+2];
   assign base_p1_s   = base_r + ADDR_ONE;
   assign base_p2_s   = base_r + ADDR_TWO;
   assign req_p1_s    = base_req_r + ADDR_ONE;
   assign a_eq_base_s = (addr_a_s == base_r);
   assign a_eq_next_s = (addr_a_s == base_p1_s);
   assign cache_s     = {hi_r, lo_r};

   // Window select and hit flag; valid in the same cycle byte_index lands on the cached pair
   always_comb begin
      enc_bytes = 24'h000000;
      win_valid = (state_r == READY) && a_eq_base_s;
      case (off_s)
         2'd0:    enc_bytes = cache_s[23:0];
         2'd1:    enc_bytes = cache_s[31:8];
         2'd2:    enc_bytes = cache_s[39:16];
         2'd3:    enc_bytes = cache_s[47:24];
         default: enc_bytes = 24'h000000;
      endcase
   end

   // RAM request decode: the read overlaps the decision cycle so data returns in the capture state
   always_comb begin
      mem_rd   = 1'b0;
      mem_addr = ADDR_ZERO;
      if (restart) begin
         mem_rd   = 1'b0;
         mem_addr = ADDR_ZERO;
      end else begin
         case (state_r)
            BOOT_LO: begin
               mem_rd   = 1'b1;
               mem_addr = ADDR_ZERO;
            end
            BOOT_HI: begin
               mem_rd   = 1'b1;
               mem_addr = ADDR_ONE;
            end
            READY: begin
               if (a_eq_base_s) begin
                  mem_rd   = 1'b0;
                  mem_addr = ADDR_ZERO;
               end else if (a_eq_next_s) begin
                  mem_rd   = 1'b1;
                  mem_addr = base_p2_s;
               end else begin
                  mem_rd   = 1'b1;
                  mem_addr = addr_a_s;
               end
            end
            MISS_HI: begin
               mem_rd   = 1'b1;
               mem_addr = req_p1_s;
            end
            default: begin
               mem_rd   = 1'b0;
               mem_addr = ADDR_ZERO;
            end
         endcase
      end
   end

   // Fetch FSM and cache registers; restart overrides every transition and drops in-flight data
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r     <= IDLE;
         lo_r        <= 32'h00000000;
         hi_r        <= 32'h00000000;
         base_r      <= ADDR_ZERO;
         base_req_r  <= ADDR_ZERO;
         bottom_word <= 32'h00000000;
         boot_done   <= 1'b0;
      end else if (restart) begin
         state_r   <= BOOT_LO;
         boot_done <= 1'b0;
      end else begin
         case (state_r)
            IDLE:     state_r <= IDLE;
            BOOT_LO:  state_r <= BOOT_HI;
            BOOT_HI: begin
               lo_r        <= mem_rdata;
               bottom_word <= mem_rdata;
               state_r     <= BOOT_CAP;
            end
            BOOT_CAP: begin
               hi_r      <= mem_rdata;
               base_r    <= ADDR_ZERO;
               boot_done <= 1'b1;
               state_r   <= READY;
            end
            READY: begin
               if (a_eq_base_s) begin
                  state_r <= READY;
               end else if (a_eq_next_s) begin
                  state_r <= SHIFT_CAP;
               end else begin
                  base_req_r <= addr_a_s;
                  state_r    <= MISS_HI;
               end
            end
            SHIFT_CAP: begin
               lo_r    <= hi_r;
               hi_r    <= mem_rdata;
               base_r  <= base_p1_s;
               state_r <= READY;
            end
            MISS_HI: begin
               lo_r    <= mem_rdata;
               state_r <= MISS_CAP;
            end
            MISS_CAP: begin
               hi_r    <= mem_rdata;
               base_r  <= base_req_r;
               state_r <= READY;
            end
            default:  state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rans_enc_fetch.sv
// Randomized bench for rans_enc_fetch: a byte-addressed file model predicts the window,
// the hit/next-word/miss latency and the RAM reads each pointer move should cause.
module tb_rans_enc_fetch;

   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          resetn;
   logic          restart;
   logic [31:0]   byte_index;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_rdata;
   logic [23:0]   enc_bytes;
   logic [31:0]   bottom_word;
   logic          win_valid;
   logic          boot_done;

   int            n_checks = 0;
   int            n_fail   = 0;
   int unsigned   mbase    = 0;
   logic [AW-1:0] addr_q[$];

   always #5 clk = ~clk;

   rans_enc_fetch #(.ADDR_W(AW)) dut (
      .clk(clk), .resetn(resetn), .restart(restart), .byte_index(byte_index),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .enc_bytes(enc_bytes), .bottom_word(bottom_word),
      .win_valid(win_valid), .boot_done(boot_done)
   );

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      case (a)
         16'd0:   return 32'h11223344;
         16'd1:   return 32'h55667788;
         16'd2:   return 32'h99AABBCC;
         16'd10:  return 32'hDEADBEEF;
         16'd11:  return 32'h01020304;
         default: return ({16'd0, a} * 32'h9E3779B1) ^ 32'hA5C3_0F96;
      endcase
   endfunction

   // The file as a flat little-endian byte array, wrapping at the RAM size.
   function automatic logic [7:0] byte_at(input int unsigned i);
      int unsigned word;
      logic [31:0] w;
      word = (i / 4) % (32'd1 << AW);
      w = mem_word(AW'(word)) >> (8 * (i % 4));
      return w[7:0];
   endfunction

   function automatic logic [23:0] exp_window(input int unsigned i);
      return {byte_at(i + 2), byte_at(i + 1), byte_at(i)};
   endfunction

   // Synchronous RAM: data one cycle after the strobe, junk otherwise.
   always @(posedge clk) begin
      if (mem_rd) begin
         mem_rdata <= mem_word(mem_addr);
         addr_q.push_back(mem_addr);
      end else begin
         mem_rdata <= $urandom;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic do_boot(input logic [31:0] idx, input bit hold_chk);
      int unsigned old_base;
      old_base = mbase;
      @(negedge clk);
      addr_q.delete();
      restart    = 1'b1;
      byte_index = idx;
      @(negedge clk);
      restart = 1'b0;
      #1;
      check_val("boot_wv0", {31'd0, win_valid}, 32'd0);
      check_val("boot_done0", {31'd0, boot_done}, 32'd0);
      if (hold_chk)
         check_val("boot_hold", {8'd0, enc_bytes}, {8'd0, exp_window(old_base * 4 + idx % 4)});
      repeat (2) begin
         @(negedge clk);
         #1;
         check_val("boot_wv_wait", {31'd0, win_valid}, 32'd0);
      end
      @(negedge clk);
      #1;
      mbase = 0;
      check_val("boot_done1", {31'd0, boot_done}, 32'd1);
      check_val("boot_wv1", {31'd0, win_valid}, 32'd1);
      check_val("boot_bottom", bottom_word, 32'h11223344);
      check_val("boot_enc", {8'd0, enc_bytes}, {8'd0, exp_window(idx)});
      check_val("boot_nrd", addr_q.size(), 32'd2);
      check_val("boot_rd0", {16'd0, addr_q[0]}, 32'd0);
      check_val("boot_rd1", {16'd0, addr_q[1]}, 32'd1);
   endtask

   task automatic step_to(input logic [31:0] idx);
      int unsigned a;
      int unsigned lat;
      int unsigned exp_rd[$];
      a = (idx / 4) % (32'd1 << AW);
      if (a == mbase) begin
         lat = 0;
      end else if (a == (mbase + 1) % (32'd1 << AW)) begin
         lat = 2;
         exp_rd.push_back((mbase + 2) % (32'd1 << AW));
      end else begin
         lat = 3;
         exp_rd.push_back(a);
         exp_rd.push_back((a + 1) % (32'd1 << AW));
      end
      @(negedge clk);
      addr_q.delete();
      byte_index = idx;
      #1;
      for (int k = 0; k < int'(lat); k++) begin
         check_val("step_wv_wait", {31'd0, win_valid}, 32'd0);
         @(negedge clk);
         #1;
      end
      mbase = a;
      check_val("step_wv", {31'd0, win_valid}, 32'd1);
      check_val("step_enc", {8'd0, enc_bytes}, {8'd0, exp_window(idx)});
      check_val("step_nrd", addr_q.size(), exp_rd.size());
      for (int k = 0; k < exp_rd.size() && k < addr_q.size(); k++)
         check_val("step_rdaddr", {16'd0, addr_q[k]}, exp_rd[k]);
      check_val("step_bottom", bottom_word, 32'h11223344);
   endtask

   initial begin
      int unsigned kind;
      int unsigned word;
      logic [31:0] idx;

      resetn     = 1'b0;
      restart    = 1'b0;
      byte_index = 32'd0;
      #2;
      check_val("rst_wv", {31'd0, win_valid}, 32'd0);
      check_val("rst_done", {31'd0, boot_done}, 32'd0);
      check_val("rst_rd", {31'd0, mem_rd}, 32'd0);
      check_val("rst_addr", {16'd0, mem_addr}, 32'd0);
      check_val("rst_enc", {8'd0, enc_bytes}, 32'd0);
      check_val("rst_bottom", bottom_word, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_val("idle_wv", {31'd0, win_valid}, 32'd0);

      do_boot(32'd0, 1'b0);
      check_val("boot_enc_const", {8'd0, enc_bytes}, 32'h00223344);
      step_to(32'd3);
      check_val("straddle_const", {8'd0, enc_bytes}, 32'h00778811);
      step_to(32'd4);
      check_val("next_const", {8'd0, enc_bytes}, 32'h00667788);
      step_to(32'd43);
      check_val("miss_const", {8'd0, enc_bytes}, 32'h000304DE);
      step_to(32'd42);
      step_to(32'd0);

      // Miss toward word 10, then restart while the first miss word is on the bus.
      @(negedge clk);
      byte_index = 32'd40;
      do_boot(32'd0, 1'b1);

      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 2);
         case (kind)
            0:       word = mbase;
            1:       word = (mbase + 1) % (32'd1 << AW);
            default: word = $urandom_range(0, (1 << AW) - 1);
         endcase
         idx = ($urandom & 32'hFFFC_0000) | (word << 2) | $urandom_range(0, 3);
         step_to(idx);
      end

      step_to(32'd400);
      do_boot(32'd2, 1'b1);

      step_to(32'h0003_FFFC);
      step_to(32'hFFFF_FFFE);
      step_to(32'h0000_0001);

      // Asynchronous reset while a next-word capture is pending.
      @(negedge clk);
      byte_index = 32'd4;
      @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check_val("arst_wv", {31'd0, win_valid}, 32'd0);
      check_val("arst_done", {31'd0, boot_done}, 32'd0);
      check_val("arst_rd", {31'd0, mem_rd}, 32'd0);
      check_val("arst_addr", {16'd0, mem_addr}, 32'd0);
      check_val("arst_enc", {8'd0, enc_bytes}, 32'd0);
      check_val("arst_bottom", bottom_word, 32'd0);
      @(negedge clk);
      resetn     = 1'b1;
      byte_index = 32'd0;
      addr_q.delete();
      repeat (3) @(negedge clk);
      #1;
      check_val("arst_idle_wv", {31'd0, win_valid}, 32'd0);
      check_val("arst_idle_nrd", addr_q.size(), 32'd0);
      mbase = 0;
      do_boot(32'd1, 1'b0);
      step_to(32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
